mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single external RAM bus between the instruction-fetch port and the MEM-stage data port of the 5-stage pipeline. It holds one bus transaction at a time and registers the read data that the IF stage and the MEMWB pipeline register capture. It raises per-stage stall requests while a port waits for service, and terminates hung transactions with a watchdog.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `SEL_W`, 4: byte-lane select width.
- `TIMEOUT`, 255: maximum bus cycles to wait for `bus_ack`, minimum 1.
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch read request; held until `if_ready`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched word; valid while `if_ready`=1.
- `if_ready` out 1: one-cycle completion pulse for the fetch port.
- `mem_req` in 1: data request; held until `mem_ready`.
- `mem_write` in 1: 1 = write, 0 = read.
- `mem_sel` in SEL_W: byte lanes.
- `mem_addr` in ADDR_W: data address.
- `mem_wdata` in DATA_W: write data.
- `mem_rdata` out DATA_W: read data; valid while `mem_ready`=1.
- `mem_ready` out 1: one-cycle completion pulse for the data port.
- `bus_en` out 1: bus transaction active.
- `bus_write` out 1: bus write strobe.
- `bus_sel` out SEL_W: bus byte lanes.
- `bus_addr` out ADDR_W: bus address.
- `bus_wdata` out DATA_W: bus write data.
- `bus_rdata` in DATA_W: bus read data; sampled when `bus_ack`=1.
- `bus_ack` in 1: slave completion.
- `bus_err` out 1: one-cycle pulse, issued together with the ready pulse, when the watchdog expires.
- `stall_if` out 1: `if_req & ~if_ready`, combinational.
- `stall_mem` out 1: `mem_req & ~mem_ready`, combinational.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - If `mem_req` and `if_req` are both high, the grant goes to the port that was not granted last. The last-grant flag resets to IF, so MEM wins the first tie.
  - If only one request is high, that port is granted.
  - On a grant: latch `addr`, `sel`, `wdata` and `write` into the bus registers (IF forces `write`=0 and `sel`=all ones), record the granted port, clear the watchdog counter, go to BUS.
- **BUS**
  - `bus_en`=1 and the bus outputs are driven from the latched registers; they are stable for the whole transaction.
  - If `bus_ack`=1: capture `bus_rdata` into the granted port's rdata register and go to RESP. On a write the rdata register is left unchanged.
  - Else if counter == TIMEOUT-1: load 0 into the granted port's rdata register, set `err_pending`, go to RESP.
  - Else increment the counter.
- **RESP**
  - The granted port's ready output is 1 for exactly this cycle.
  - `bus_err` equals `err_pending`; `err_pending` clears on exit.
  - Update the last-grant flag, go to IDLE.
  - A new request is not accepted in RESP. This prevents re-issuing the request that is completing.
- Request inputs are sampled only in IDLE. Changes to `addr`/`wdata` during BUS have no effect.
- `bus_ack` outside BUS is ignored.
- Reset mid-transaction: state goes to IDLE immediately, `bus_en` drops asynchronously, and the outstanding transaction is discarded with no ready pulse.

## Timing
- Reset values:
  - state IDLE; `bus_en`, `bus_write`, `bus_err`, `if_ready`, `mem_ready` = 0.
  - `bus_sel`, `bus_addr`, `bus_wdata`, `if_rdata`, `mem_rdata` = 0.
  - counter 0; last-grant flag = IF.
- Registered outputs: `bus_*`, `*_rdata`, `*_ready`, `bus_err`. Stall outputs are combinational.
- Latency: request seen at edge E0 → `bus_en` high from E0 → `bus_ack` sampled at edge E0+k (k ≥ 1) → ready high in the cycle after edge E0+k → IDLE after edge E0+k+1.
- Minimum turnaround is 3 cycles request-to-IDLE (zero-wait slave). Back-to-back service of one port costs 3 cycles per access.
- Watchdog: BUS lasts at most TIMEOUT cycles; `bus_err` is asserted in the cycle after the TIMEOUT-th BUS cycle.
- Requesters must hold their request through the ready cycle and may drop or change it in the following cycle.

## Test plan
- **Single fetch**: `if_req`=1, `if_addr`=0x00000100; slave acks in the first BUS cycle with 0x24080005 → `bus_en`=1 for 1 cycle, `bus_write`=0, `bus_sel`=0xF, `if_ready` pulses once with `if_rdata`=0x24080005, `stall_if`=1 until the ready cycle.
- **Contention**: `if_req` and `mem_req` rise together (read 0x00000200, ack data 0xDEADBEEF) → MEM served first (`mem_rdata`=0xDEADBEEF), then IF. The next tie goes to MEM again.
- **Write with wait states**: `mem_write`=1, `mem_sel`=0x3, `mem_wdata`=0x0000ABCD, ack after 4 BUS cycles → bus outputs stable for 4 cycles, then one `mem_ready` pulse, `mem_rdata` unchanged, `bus_err`=0.
- **Timeout**: TIMEOUT=4, `bus_ack` never asserted → exactly 4 BUS cycles, then `mem_ready`=1 and `bus_err`=1 in the same cycle, `mem_rdata`=0, FSM back in IDLE.
- **Reset mid-transaction**: `rst` low in the 2nd BUS cycle → `bus_en`=0 immediately, no ready pulse. After release, a held `if_req` is granted anew.
- **Stray ack**: `bus_ack`=1 while IDLE with no request → no ready pulse, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external RAM bus between the IF fetch port and the MEM data port.
// Latency: grant on the request edge, ready pulse the cycle after bus_ack (3 cycles minimum).
// Backpressure: a waiting port sees stall_* high until its ready pulse; one transaction in flight.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    // MEM-stage data port
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    // external RAM bus
    output logic              bus_en,
    output logic              bus_write,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err,
    // pipeline stall requests
    output logic              stall_if,
    output logic              stall_mem
);

    // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wd_cnt;      // BUS cycles elapsed in the current transaction
    logic             gnt_mem;     // owner of the current transaction: 1 = MEM, 0 = IF
    logic             last_mem;    // owner of the previous transaction: 1 = MEM, 0 = IF
    logic             err_pending; // watchdog fired; only ever set while in RESP
    logic             grant_mem;

    // On a tie the port that did not own the previous transaction wins.
    assign grant_mem = mem_req & (~if_req | ~last_mem);

    // The error flag is already a register that is only high in RESP.
    assign bus_err = err_pending;

    // A port stalls for as long as it requests and has not yet seen its ready pulse.
    assign stall_if  = if_req  & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

    // Arbitration FSM with registered bus, read-data and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            gnt_mem     <= 1'b0;
            last_mem    <= 1'b0;
            err_pending <= 1'b0;
            bus_en      <= 1'b0;
            bus_write   <= 1'b0;
            bus_sel     <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || mem_req) begin
                        gnt_mem <= grant_mem;
                        wd_cnt  <= '0;
                        bus_en  <= 1'b1;
                        state   <= BUS;
                        if (grant_mem) begin
                            bus_write <= mem_write;
                            bus_sel   <= mem_sel;
                            bus_addr  <= mem_addr;
                            bus_wdata <= mem_wdata;
                        end else begin
                            // fetches are always full-word reads
                            bus_write <= 1'b0;
                            bus_sel   <= '1;
                            bus_addr  <= if_addr;
                            bus_wdata <= '0;
                        end
                    end
                end

                BUS: begin
                    if (bus_ack) begin
                        // writes leave the port's read-data register untouched
                        if (!bus_write) begin
                            if (gnt_mem) mem_rdata <= bus_rdata;
                            else         if_rdata  <= bus_rdata;
                        end
                        bus_en    <= 1'b0;
                        mem_ready <= gnt_mem;
                        if_ready  <= ~gnt_mem;
                        state     <= RESP;
                    end else if (wd_cnt == CNT_LAST) begin
                        // hung slave: complete the access with zero data and an error flag
                        if (gnt_mem) mem_rdata <= '0;
                        else         if_rdata  <= '0;
                        err_pending <= 1'b1;
                        bus_en      <= 1'b0;
                        mem_ready   <= gnt_mem;
                        if_ready    <= ~gnt_mem;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    // requests are ignored here so the completing request is not reissued
                    if_ready    <= 1'b0;
                    mem_ready   <= 1'b0;
                    err_pending <= 1'b0;
                    last_mem    <= gnt_mem;
                    state       <= IDLE;
                end

                default: begin
                    bus_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_req = 1'b0;
    logic          mem_write = 1'b0;
    logic [SW-1:0] mem_sel = '0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          bus_en;
    logic          bus_write;
    logic [SW-1:0] bus_sel;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;
    logic          bus_err;
    logic          stall_if;
    logic          stall_mem;

    mem_bus_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .SEL_W  (SW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .mem_req  (mem_req),
        .mem_write(mem_write),
        .mem_sel  (mem_sel),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .bus_en   (bus_en),
        .bus_write(bus_write),
        .bus_sel  (bus_sel),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          if_q[$];
    exp_t          mem_q[$];
    exp_t          mon_e;
    int            vectors = 0;
    int            miscompares = 0;
    int            if_ready_cnt = 0;
    int            mem_ready_cnt = 0;
    logic [DW-1:0] mem_model = '0;   // expected content of the MEM read-data register

    // slave model controls: ack in the ack_wait-th BUS cycle (0 = never)
    int            ack_wait = 1;
    logic [DW-1:0] ack_data = '0;
    logic          stray_ack = 1'b0;
    int            bus_cyc = 0;

    // Slave: counts BUS cycles and raises bus_ack in the configured one.
    always @(negedge clk) begin
        if (bus_en) begin
            bus_cyc = bus_cyc + 1;
            bus_ack = (ack_wait != 0) && (bus_cyc == ack_wait);
        end else begin
            bus_cyc = 0;
            bus_ack = stray_ack;
        end
        bus_rdata = ack_data;
    end

    // Monitor: every ready pulse pops the scoreboard of its port.
    always @(posedge clk) begin
        #1;
        if (if_ready && mem_ready) begin
            vectors++; miscompares++;
            $display("FAIL dual_ready: both ready outputs high at %0t", $time);
        end
        if (if_ready) begin
            if_ready_cnt++;
            vectors++;
            if (if_q.size() == 0) begin
                miscompares++;
                $display("FAIL if_unexpected_ready: pulse with nothing outstanding at %0t", $time);
            end else begin
                mon_e = if_q.pop_front();
                if (if_rdata !== mon_e.rdata || bus_err !== mon_e.err) begin
                    miscompares++;
                    $display("FAIL if_response: got rdata %h err %b, expected rdata %h err %b",
                             if_rdata, bus_err, mon_e.rdata, mon_e.err);
                end
            end
        end
        if (mem_ready) begin
            mem_ready_cnt++;
            vectors++;
            if (mem_q.size() == 0) begin
                miscompares++;
                $display("FAIL mem_unexpected_ready: pulse with nothing outstanding at %0t", $time);
            end else begin
                mon_e = mem_q.pop_front();
                if (mem_rdata !== mon_e.rdata || bus_err !== mon_e.err) begin
                    miscompares++;
                    $display("FAIL mem_response: got rdata %h err %b, expected rdata %h err %b",
                             mem_rdata, bus_err, mon_e.rdata, mon_e.err);
                end
            end
        end
        if (!if_ready && !mem_ready && bus_err === 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL bus_err_alone: bus_err high without a ready pulse at %0t", $time);
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus_en, bus_write, bus_err, if_ready, mem_ready, stall_if, stall_mem} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus_en, bus_write, bus_err, if_ready, mem_ready, stall_if, stall_mem});
        end
        vectors++;
        if ({bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: sel %h addr %h wdata %h if_rdata %h mem_rdata %h, expected all 0",
                     bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: bus_en %b expected 0", bus_en);
        end
    endtask

    task automatic test_single_fetch();
        int en_cycles;
        int ready_at;
        int cnt0;
        en_cycles = 0;
        ready_at  = -1;
        cnt0      = if_ready_cnt;
        @(negedge clk);
        ack_wait = 1;
        ack_data = 32'h2408_0005;
        if_q.push_back('{32'h2408_0005, 1'b0});
        if_addr = 32'h0000_0100;
        if_req  = 1'b1;
        #1;
        vectors++;
        if (stall_if !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_stall_start: stall_if %b expected 1", stall_if);
        end
        for (int n = 0; n < 20 && ready_at < 0; n++) begin
            @(negedge clk);
            if (bus_en) begin
                en_cycles++;
                vectors++;
                if ({bus_write, bus_sel, bus_addr} !== {1'b0, 4'hF, 32'h0000_0100}) begin
                    miscompares++;
                    $display("FAIL fetch_bus: write %b sel %h addr %h, expected 0 f 00000100",
                             bus_write, bus_sel, bus_addr);
                end
            end
            vectors++;
            if (if_ready) begin
                ready_at = n;
                if (stall_if !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fetch_stall_ready: stall_if %b expected 0", stall_if);
                end
            end else if (stall_if !== 1'b1) begin
                miscompares++;
                $display("FAIL fetch_stall_wait: stall_if %b expected 1", stall_if);
            end
        end
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_at != 1 || en_cycles != 1) begin
            miscompares++;
            $display("FAIL fetch_timing: ready after %0d cycles with %0d bus cycles, expected 1 and 1",
                     ready_at, en_cycles);
        end
        vectors++;
        if (if_ready !== 1'b0 || bus_en !== 1'b0 || if_ready_cnt != cnt0 + 1) begin
            miscompares++;
            $display("FAIL fetch_one_pulse: if_ready %b bus_en %b pulses %0d, expected 0 0 1",
                     if_ready, bus_en, if_ready_cnt - cnt0);
        end
    endtask

    task automatic test_contention();
        logic [36:0] exp_bus;
        bit          mem_done;
        bit          if_done;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            ack_wait  = 1;
            ack_data  = 32'hDEAD_BEEF;
            mem_model = 32'hDEAD_BEEF;
            mem_q.push_back('{32'hDEAD_BEEF, 1'b0});
            if_q.push_back('{32'(32'h1111_0000 + r), 1'b0});
            mem_write = 1'b0;
            mem_sel   = 4'hC;
            mem_addr  = 32'h0000_0200;
            if_addr   = 32'h0000_0104;
            mem_req   = 1'b1;
            if_req    = 1'b1;
            mem_done  = 1'b0;
            if_done   = 1'b0;
            for (int n = 0; n < 40 && !if_done; n++) begin
                @(negedge clk);
                if (bus_en) begin
                    exp_bus = mem_done ? {1'b0, 4'hF, 32'h0000_0104} : {1'b0, 4'hC, 32'h0000_0200};
                    vectors++;
                    if ({bus_write, bus_sel, bus_addr} !== exp_bus) begin
                        miscompares++;
                        $display("FAIL contention_bus round %0d: got %h expected %h",
                                 r, {bus_write, bus_sel, bus_addr}, exp_bus);
                    end
                end
                if (mem_ready) begin
                    mem_done = 1'b1;
                    ack_data = 32'(32'h1111_0000 + r);
                    @(posedge clk);
                    #1 mem_req = 1'b0;
                end else if (if_ready) begin
                    if_done = 1'b1;
                    vectors++;
                    if (!mem_done) begin
                        miscompares++;
                        $display("FAIL contention_order round %0d: IF served first, expected MEM first", r);
                    end
                    @(posedge clk);
                    #1 if_req = 1'b0;
                end
            end
            vectors++;
            if (!if_done || !mem_done) begin
                miscompares++;
                $display("FAIL contention_timeout round %0d: mem_done %b if_done %b expected 1 1",
                         r, mem_done, if_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_at;
        int second_at;
        first_at  = -1;
        second_at = -1;
        @(negedge clk);
        ack_wait = 1;
        ack_data = 32'hA000_0001;
        if_q.push_back('{32'hA000_0001, 1'b0});
        if_q.push_back('{32'hA000_0002, 1'b0});
        if_addr = 32'h0000_0108;
        if_req  = 1'b1;
        for (int n = 0; n < 30 && second_at < 0; n++) begin
            @(negedge clk);
            if (if_ready) begin
                if (first_at < 0) begin
                    first_at = n;
                    ack_data = 32'hA000_0002;
                end else begin
                    second_at = n;
                end
            end
        end
        @(posedge clk);
        #1 if_req = 1'b0;
        vectors++;
        if (first_at != 1 || second_at - first_at != 3) begin
            miscompares++;
            $display("FAIL back_to_back: ready at %0d and %0d, expected 1 and 4", first_at, second_at);
        end
    endtask

    task automatic test_write_wait();
        int en_cycles;
        int ready_at;
        en_cycles = 0;
        ready_at  = -1;
        @(negedge clk);
        ack_wait = 4;
        mem_q.push_back('{mem_model, 1'b0});
        mem_write = 1'b1;
        mem_sel   = 4'h3;
        mem_addr  = 32'h0000_0300;
        mem_wdata = 32'h0000_ABCD;
        mem_req   = 1'b1;
        for (int n = 0; n < 20 && ready_at < 0; n++) begin
            @(negedge clk);
            if (bus_en) begin
                en_cycles++;
                vectors++;
                if ({bus_write, bus_sel, bus_addr, bus_wdata} !== {1'b1, 4'h3, 32'h0000_0300, 32'h0000_ABCD}) begin
                    miscompares++;
                    $display("FAIL write_bus cycle %0d: write %b sel %h addr %h wdata %h, expected 1 3 00000300 0000abcd",
                             en_cycles, bus_write, bus_sel, bus_addr, bus_wdata);
                end
                // changes during BUS must not reach the bus
                mem_addr  = 32'hFFFF_FFFC;
                mem_wdata = 32'h5555_5555;
            end
            vectors++;
            if (mem_ready) begin
                ready_at = n;
                if (stall_mem !== 1'b0) begin
                    miscompares++;
                    $display("FAIL write_stall_ready: stall_mem %b expected 0", stall_mem);
                end
            end else if (stall_mem !== 1'b1) begin
                miscompares++;
                $display("FAIL write_stall_wait: stall_mem %b expected 1", stall_mem);
            end
        end
        @(posedge clk);
        #1;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        vectors++;
        if (en_cycles != 4 || ready_at != 4) begin
            miscompares++;
            $display("FAIL write_timing: %0d bus cycles, ready at %0d, expected 4 and 4", en_cycles, ready_at);
        end
    endtask

    task automatic test_timeout();
        int en_cycles;
        int ready_at;
        en_cycles = 0;
        ready_at  = -1;
        @(negedge clk);
        ack_wait  = 0;
        mem_model = '0;
        mem_q.push_back('{32'h0, 1'b1});
        mem_write = 1'b0;
        mem_sel   = 4'hF;
        mem_addr  = 32'h0000_0400;
        mem_req   = 1'b1;
        for (int n = 0; n < 20 && ready_at < 0; n++) begin
            @(negedge clk);
            if (bus_en) en_cycles++;
            if (mem_ready) begin
                ready_at = n;
                vectors++;
                if (bus_err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL timeout_err: bus_err %b expected 1 with mem_ready", bus_err);
                end
            end
        end
        @(posedge clk);
        #1 mem_req = 1'b0;
        vectors++;
        if (en_cycles != TO || ready_at != TO) begin
            miscompares++;
            $display("FAIL timeout_timing: %0d bus cycles, ready at %0d, expected %0d and %0d",
                     en_cycles, ready_at, TO, TO);
        end
        @(negedge clk);
        vectors++;
        if ({bus_err, mem_ready, bus_en} !== 3'b000 || mem_rdata !== '0) begin
            miscompares++;
            $display("FAIL timeout_after: err/ready/en %b rdata %h, expected 000 and 0",
                     {bus_err, mem_ready, bus_en}, mem_rdata);
        end
        ack_wait = 1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int cnt0;
        int ready_at;
        cyc      = 0;
        ready_at = -1;
        @(negedge clk);
        ack_wait = 0;
        if_addr  = 32'h0000_0500;
        if_req   = 1'b1;
        for (int n = 0; n < 20 && cyc < 2; n++) begin
            @(negedge clk);
            if (bus_en) cyc++;
        end
        cnt0 = if_ready_cnt;
        rst  = 1'b0;
        #1;
        vectors++;
        if (cyc != 2 || bus_en !== 1'b0 || if_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_drop: bus cycles %0d bus_en %b if_ready %b, expected 2 0 0",
                     cyc, bus_en, if_ready);
        end
        repeat (2) @(negedge clk);
        ack_wait  = 1;
        ack_data  = 32'hCAFE_F00D;
        mem_model = '0;
        if_q.push_back('{32'hCAFE_F00D, 1'b0});
        rst = 1'b1;
        for (int n = 0; n < 20 && ready_at < 0; n++) begin
            @(negedge clk);
            if (if_ready) ready_at = n;
        end
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_at != 1 || if_ready_cnt != cnt0 + 1) begin
            miscompares++;
            $display("FAIL reset_mid_regrant: ready at %0d with %0d pulses, expected 1 and 1",
                     ready_at, if_ready_cnt - cnt0);
        end
    endtask

    task automatic test_stray_ack();
        int cnt_if;
        int cnt_mem;
        int ready_at;
        ready_at = -1;
        @(negedge clk);
        cnt_if    = if_ready_cnt;
        cnt_mem   = mem_ready_cnt;
        stray_ack = 1'b1;
        ack_data  = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (bus_en !== 1'b0 || if_ready !== 1'b0 || mem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stray_ack: bus_en %b if_ready %b mem_ready %b, expected 0 0 0",
                         bus_en, if_ready, mem_ready);
            end
        end
        stray_ack = 1'b0;
        ack_wait  = 1;
        ack_data  = 32'h0BAD_CAFE;
        if_q.push_back('{32'h0BAD_CAFE, 1'b0});
        if_addr = 32'h0000_0600;
        if_req  = 1'b1;
        for (int n = 0; n < 20 && ready_at < 0; n++) begin
            @(negedge clk);
            if (if_ready) ready_at = n;
        end
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_at != 1 || if_ready_cnt != cnt_if + 1 || mem_ready_cnt != cnt_mem) begin
            miscompares++;
            $display("FAIL stray_ack_after: ready at %0d, if pulses %0d, mem pulses %0d, expected 1 1 0",
                     ready_at, if_ready_cnt - cnt_if, mem_ready_cnt - cnt_mem);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_back_to_back();
        test_write_wait();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        repeat (3) @(negedge clk);
        vectors++;
        if (if_q.size() != 0 || mem_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d IF and %0d MEM responses outstanding, expected 0 and 0",
                     if_q.size(), mem_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, miscompares so far %0d", miscompares);
        $fatal(1);
    end

endmodule
